tcdm_bank_responder: RTL and testbench

Target-side endpoint of one HCI memory-side channel, one instance per TCDM bank. It sits between a single `mems` initiator port of the cluster TCDM interconnect and one single-port SRAM macro with a 1-cycle read latency. It accepts the req/gnt request phase and drives the SRAM. It returns responses over the r_valid/r_ready response phase, with a small response buffer so that response back-pressure never loses SRAM read data.

---
 rtl/tcdm_bank_pkg.sv | 15 +
 rtl/tcdm_rsp_fifo.sv | 59 +++++
 rtl/tcdm_bank_responder.sv | 118 +++++++++++
 tb/tb_tcdm_bank_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_bank_pkg.sv
// Shared types and constants for the TCDM bank responder and its response FIFO.
package tcdm_bank_pkg;

  localparam int TCDM_DW = 32;
  localparam int TCDM_IW = 21;

  // HCI encodes a read as wen=1
  localparam logic HCI_WEN_READ = 1'b1;

  typedef struct packed {
    logic [TCDM_DW-1:0] data;
    logic [TCDM_IW-1:0] id;
  } tcdm_rsp_t;

endpackage

// File: rtl/tcdm_rsp_fifo.sv
// Response buffer: RSP_DEPTH-entry FIFO with wrapping pointers and occupancy count.
module tcdm_rsp_fifo #(
  parameter int W     = 53,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [OW-1:0] occ_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0] occ_q, occ_d;

  // Explicit wrap so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push_i) wptr_d = ptr_inc(wptr_q);
    if (pop_i)  rptr_d = ptr_inc(rptr_q);
    if (push_i && !pop_i)      occ_d = occ_q + 1'b1;
    else if (!push_i && pop_i) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign occ_o   = occ_q;
  assign full_o  = (occ_q == OW'(DEPTH));
  assign empty_o = (occ_q == '0);

endmodule

// File: rtl/tcdm_bank_responder.sv
// HCI memory-side target endpoint for one TCDM bank: drives a 1-cycle SRAM and returns
// in-order responses over r_valid/r_ready, buffering read data under back-pressure.
module tcdm_bank_responder
  import tcdm_bank_pkg::*;
#(
  parameter int DW         = TCDM_DW,
  parameter int AW         = 13,
  parameter int IW         = TCDM_IW,
  parameter int RSP_DEPTH  = 2,
  parameter int WRITE_RESP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   add_i,
  input  logic            wen_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [IW-1:0]   id_i,
  output logic            r_valid_o,
  input  logic            r_ready_i,
  output logic [DW-1:0]   r_data_o,
  output logic [IW-1:0]   r_id_o,
  output logic            r_opc_o,
  output logic            sram_req_o,
  output logic            sram_we_o,
  output logic [AW-1:0]   sram_addr_o,
  output logic [DW-1:0]   sram_wdata_o,
  output logic [DW/8-1:0] sram_be_o,
  input  logic [DW-1:0]   sram_rdata_i
);

  localparam int OW = $clog2(RSP_DEPTH + 1);
  localparam int CW = OW + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } rsp_t;

  logic          is_read, responding, accept;
  logic [CW-1:0] credit_used;
  logic          v1_q, is_read1_q;
  logic [IW-1:0] id1_q;
  rsp_t          st1_rsp, head_rsp, out_rsp;
  logic          push, pop, full, empty;
  logic [OW-1:0] occ;

  assign is_read    = (wen_i == HCI_WEN_READ);
  assign responding = is_read || (WRITE_RESP != 0);

  // Credits cover buffered entries plus the response still in stage 1, so the
  // SRAM data arriving next cycle always has a slot; r_ready_i stays out of this path.
  assign credit_used = CW'(occ) + CW'(v1_q);
  assign gnt_o  = req_i && !rst_i && (!responding || (credit_used < CW'(RSP_DEPTH)));
  assign accept = gnt_o;

  assign sram_req_o   = accept;
  assign sram_we_o    = !wen_i;
  assign sram_addr_o  = add_i;
  assign sram_wdata_o = data_i;
  assign sram_be_o    = is_read ? '1 : be_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q       <= 1'b0;
      is_read1_q <= 1'b0;
      id1_q      <= '0;
    end else begin
      v1_q <= accept && responding;
      if (accept && responding) begin
        is_read1_q <= is_read;
        id1_q      <= id_i;
      end
    end
  end

  assign st1_rsp.data = is_read1_q ? sram_rdata_i : '0;
  assign st1_rsp.id   = id1_q;

  // Bypass only when nothing older is queued; otherwise stage 1 always lands in the FIFO
  assign pop  = !empty && r_ready_i;
  assign push = v1_q && !(empty && r_ready_i);

  tcdm_rsp_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (st1_rsp),
    .rdata_o (head_rsp),
    .occ_o   (occ),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    out_rsp = '0;
    if (!empty)    out_rsp = head_rsp;
    else if (v1_q) out_rsp = st1_rsp;
  end

  assign r_valid_o = !empty || v1_q;
  assign r_data_o  = out_rsp.data;
  assign r_id_o    = out_rsp.id;
  assign r_opc_o   = 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench: queue-based response model checked every cycle, plus literal expectations.
module tb_tcdm_bank_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wen, rdy;
  logic [12:0] add;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [20:0] id;
  logic        gnt, rv, ropc, sreq, swe;
  logic [31:0] rdata, swdata, srdata;
  logic [20:0] rid;
  logic [12:0] saddr;
  logic [3:0]  sbe;

  logic        req0, wen0, rdy0;
  logic [12:0] add0;
  logic [31:0] wdata0;
  logic [3:0]  be0;
  logic [20:0] id0;
  logic        gnt0, rv0, ropc0, sreq0, swe0;
  logic [31:0] rdata0, swdata0;
  logic [31:0] srdata0 = 32'h1234_5678;
  logic [20:0] rid0;
  logic [12:0] saddr0;
  logic [3:0]  sbe0;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  logic [31:0] mem     [0:8191];
  logic [31:0] ref_mem [0:8191];

  always #5 clk = ~clk;

  tcdm_bank_responder #(.DW(32), .AW(13), .IW(21), .RSP_DEPTH(2), .WRITE_RESP(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen),
    .data_i(wdata), .be_i(be), .id_i(id), .r_valid_o(rv), .r_ready_i(rdy),
    .r_data_o(rdata), .r_id_o(rid), .r_opc_o(ropc), .sram_req_o(sreq), .sram_we_o(swe),
    .sram_addr_o(saddr), .sram_wdata_o(swdata), .sram_be_o(sbe), .sram_rdata_i(srdata)
  );

  tcdm_bank_responder #(.DW(32), .AW(13), .IW(21), .RSP_DEPTH(2), .WRITE_RESP(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .gnt_o(gnt0), .add_i(add0), .wen_i(wen0),
    .data_i(wdata0), .be_i(be0), .id_i(id0), .r_valid_o(rv0), .r_ready_i(rdy0),
    .r_data_o(rdata0), .r_id_o(rid0), .r_opc_o(ropc0), .sram_req_o(sreq0), .sram_we_o(swe0),
    .sram_addr_o(saddr0), .sram_wdata_o(swdata0), .sram_be_o(sbe0), .sram_rdata_i(srdata0)
  );

  // SRAM macro model: 1-cycle read latency, byte-masked writes
  always @(posedge clk) begin
    if (sreq) begin
      if (swe) begin
        for (int b = 0; b < 4; b++)
          if (sbe[b]) mem[saddr][b*8 +: 8] <= swdata[b*8 +: 8];
      end else begin
        srdata <= mem[saddr];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: every accepted responding request is outstanding until popped; it becomes
  // visible the cycle after acceptance, and grant needs fewer than 2 outstanding.
  typedef struct {
    logic [31:0] d;
    logic [20:0] id;
    int          av;
  } exp_t;
  exp_t q[$];

  initial begin
    int   cyc = 0;
    logic ev, eg;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      ev = (q.size() != 0) && (q[0].av <= cyc);
      eg = req && !rst && (q.size() < 2);
      if (chk_en) begin
        chk("m_gnt", gnt, eg);
        chk("m_sram_req", sreq, eg);
        chk("m_r_valid", rv, ev);
        chk("m_r_opc", ropc, 0);
        if (ev) begin
          chk("m_r_data", rdata, q[0].d);
          chk("m_r_id", rid, q[0].id);
        end
        if (eg) begin
          chk("m_sram_we", swe, !wen);
          chk("m_sram_addr", saddr, add);
          chk("m_sram_be", sbe, wen ? 4'hF : be);
        end
      end
      if (rst) q.delete();
      else begin
        if (ev && rdy) void'(q.pop_front());
        if (eg) begin
          e.d  = wen ? ref_mem[add] : 32'h0;
          e.id = id;
          e.av = cyc + 1;
          q.push_back(e);
          if (!wen)
            for (int b = 0; b < 4; b++)
              if (be[b]) ref_mem[add][b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  task automatic idle_in();
    req = 0; wen = 1; add = '0; wdata = '0; be = '0; id = '0;
  endtask
  task automatic rd(input logic [12:0] a, input logic [20:0] i);
    req = 1; wen = 1; add = a; wdata = '0; be = '0; id = i;
  endtask
  task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic [20:0] i);
    req = 1; wen = 0; add = a; wdata = d; be = b; id = i;
  endtask

  initial begin
    int ng;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[13'h10] = 32'hA5A5_0001;  mem[13'h11] = 32'hA5A5_0002;
    mem[13'h20] = 32'h2000_0000;  mem[13'h21] = 32'h2000_0001;
    mem[13'h22] = 32'h2000_0002;  mem[13'h40] = 32'h4000_0000;
    mem[13'h41] = 32'h4000_0001;  mem[13'h42] = 32'h4000_0002;
    for (int i = 0; i < 8192; i++) ref_mem[i] = mem[i];
    srdata = '0;
    idle_in(); rdy = 1; rst = 1;
    req0 = 0; wen0 = 1; add0 = '0; wdata0 = '0; be0 = '0; id0 = '0; rdy0 = 0;

    // reset
    tick(); tick();
    rd(13'h10, 1);
    smp(); chk("rst_gnt", gnt, 0); chk("rst_sram_req", sreq, 0); chk("rst_gnt0", gnt0, 0);
    tick();
    rst = 0; idle_in();
    smp(); chk("rst_rvalid", rv, 0); chk("rst_rdata", rdata, 0); chk("rst_rid", rid, 0);
    chk_en = 1;
    tick();

    // back-to-back reads
    rd(13'h10, 3);
    smp(); chk("b2b_gnt0", gnt, 1); chk("b2b_noresp", rv, 0);
    tick(); rd(13'h11, 4);
    smp(); chk("b2b_gnt1", gnt, 1); chk("b2b_rv1", rv, 1);
    chk("b2b_d1", rdata, 32'hA5A5_0001); chk("b2b_id1", rid, 3);
    tick(); idle_in();
    smp(); chk("b2b_rv2", rv, 1); chk("b2b_d2", rdata, 32'hA5A5_0002); chk("b2b_id2", rid, 4);
    tick();
    smp(); chk("b2b_idle", rv, 0);
    tick();

    // back-pressure
    rdy = 0; ng = 0;
    rd(13'h20, 5); smp(); ng += int'(gnt); tick();
    rd(13'h21, 6); smp(); ng += int'(gnt); tick();
    rd(13'h22, 7); smp(); ng += int'(gnt);
    chk("bp_gnt_full", gnt, 0); chk("bp_grants", ng, 2); chk("bp_hold_id", rid, 5);
    tick();
    rdy = 1;
    smp(); chk("bp_ret_id5", rid, 5); chk("bp_still_full", gnt, 0);
    tick();
    smp(); chk("bp_ret_id6", rid, 6); chk("bp_third_gnt", gnt, 1);
    tick(); idle_in();
    smp(); chk("bp_ret_id7", rid, 7); chk("bp_ret_d7", rdata, 32'h2000_0002);
    tick();

    // byte-enabled write then read
    wr(13'h30, 32'hDEAD_BEEF, 4'b0011, 9);
    smp(); chk("bw_gnt", gnt, 1);
    tick(); rd(13'h30, 10);
    smp(); chk("bw_wrsp_v", rv, 1); chk("bw_wrsp_d", rdata, 0); chk("bw_wrsp_id", rid, 9);
    tick(); idle_in();
    smp(); chk("bw_rd_d", rdata, 32'h0000_BEEF); chk("bw_rd_id", rid, 10);
    tick();

    // simultaneous push and pop
    rdy = 0; rd(13'h40, 11); smp(); tick();
    rd(13'h41, 12); smp(); chk("pp_gnt2", gnt, 1); tick();
    idle_in(); rdy = 1;
    smp(); chk("pp_head_id", rid, 11); chk("pp_head_d", rdata, 32'h4000_0000);
    tick(); rd(13'h42, 13);
    smp(); chk("pp_occ1_gnt", gnt, 1); chk("pp_second_id", rid, 12);
    tick(); idle_in();
    smp(); chk("pp_third_id", rid, 13); chk("pp_third_d", rdata, 32'h4000_0002);
    tick();
    smp(); chk("pp_drained", rv, 0);
    tick();

    // reset mid-operation
    rdy = 0; rd(13'h20, 20); smp(); tick();
    rd(13'h21, 21); smp(); tick();
    idle_in(); smp(); chk("mr_pending", rid, 20); tick();
    rst = 1; rd(13'h22, 23);
    smp(); chk("mr_gnt_rst", gnt, 0); chk("mr_sreq_rst", sreq, 0);
    tick();
    rst = 0; rd(13'h10, 22); rdy = 1;
    smp(); chk("mr_rv_clr", rv, 0); chk("mr_rdata_clr", rdata, 0); chk("mr_rid_clr", rid, 0);
    chk("mr_fresh_gnt", gnt, 1);
    tick(); idle_in();
    smp(); chk("mr_lat_rv", rv, 1); chk("mr_lat_d", rdata, 32'hA5A5_0001); chk("mr_lat_id", rid, 22);
    tick();
    smp(); chk("mr_end", rv, 0);
    tick();

    // silent writes (WRITE_RESP=0)
    rdy0 = 0;
    for (int k = 0; k < 4; k++) begin
      req0 = 1; wen0 = 0; add0 = 13'(k); wdata0 = 32'hF00D_0000 + k; be0 = 4'hF; id0 = 21'(k);
      smp();
      chk("sw_gnt", gnt0, 1); chk("sw_rv", rv0, 0); chk("sw_sreq", sreq0, 1);
      chk("sw_we", swe0, 1); chk("sw_addr", saddr0, k); chk("sw_wdata", swdata0, 32'hF00D_0000 + k);
      chk("sw_be", sbe0, 4'hF); chk("sw_opc", ropc0, 0);
      tick();
    end
    wen0 = 1; add0 = 13'h5; id0 = 30;
    smp(); chk("sw_rd1_gnt", gnt0, 1); chk("sw_after_rv", rv0, 0);
    tick(); id0 = 31;
    smp(); chk("sw_occ0_gnt", gnt0, 1); chk("sw_rd1_rv", rv0, 1);
    chk("sw_rd1_id", rid0, 30); chk("sw_rd1_d", rdata0, 32'h1234_5678);
    tick(); id0 = 32;
    smp(); chk("sw_full_gnt", gnt0, 0);
    tick(); req0 = 0; rdy0 = 1;
    smp(); chk("sw_ret30", rid0, 30);
    tick();
    smp(); chk("sw_ret31", rid0, 31);
    tick();
    smp(); chk("sw_drained", rv0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
